// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Optional overflow output is enabled with SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  // Bits needed to count 0..w-1, never less than one.
  function automatic int cnt_width(input int w);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < w) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Single-bit full adder used as the datapath of the serial adder.
// Purely combinational.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder bit per clock, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the two's-complement ovf output.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;

  serial_fa_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB as older bits move toward the LSB.
  assign sum_nxt = (sum_sr >> 1) | {fa_sum, {(WIDTH-1){1'b0}}};

  // Control FSM plus shift datapath; all outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum_out  <= '0;
      cout_out <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
      sum_sr   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf      <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a_in;
            b_sr   <= b_in;
            carry  <= cin;
            cnt    <= '0;
            sum_sr <= '0;
            busy   <= 1'b1;
            state  <= ADD;
          end
        end
        ADD: begin
          sum_sr <= sum_nxt;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= fa_cout;
          if (cnt == LAST) begin
            sum_out  <= sum_nxt;
            cout_out <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            // carry here is the carry into the MSB
            ovf      <= carry ^ fa_cout;
`endif
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8).
// Covers ovf checks when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start for a single edge, then scramble the operands.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = ~a;
    b_in  = ~b;
    cin   = ~c;
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    cin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (sum_out !== 8'h00 || cout_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: sum=%h cout=%b want 00 0", sum_out, cout_out);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: ovf=%b want 0", ovf);
    end
`endif
  endtask

  task automatic test_zero;
    int bad;
    issue(8'h00, 8'h00, 1'b0);
    bad = 0;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL zero_busy: bad_cycles=%0d want 0", bad);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b want 1 0", done, busy);
    end
    checks++;
    if (sum_out !== 8'h00 || cout_out !== 1'b0) begin
      errors++;
      $display("FAIL zero_sum: sum=%h cout=%b want 00 0", sum_out, cout_out);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse: done=%b want 0", done);
    end
  endtask

  task automatic test_wrap;
    issue(8'hFF, 8'h01, 1'b0);
    repeat (W + 1) @(negedge clk);
    checks++;
    if (done !== 1'b1 || sum_out !== 8'h00 || cout_out !== 1'b1) begin
      errors++;
      $display("FAIL wrap: done=%b sum=%h cout=%b want 1 00 1",
               done, sum_out, cout_out);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL wrap_ovf: ovf=%b want 0", ovf);
    end
`endif
  endtask

  task automatic test_back_to_back;
    issue(8'hA5, 8'h5A, 1'b1);
    repeat (W + 1) @(negedge clk);
    checks++;
    if (done !== 1'b1 || sum_out !== 8'h00 || cout_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: done=%b sum=%h cout=%b want 1 00 1",
               done, sum_out, cout_out);
    end
    issue(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || sum_out !== 8'h00) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b sum=%h want 1 00", busy, sum_out);
    end
    repeat (W) @(negedge clk);
    checks++;
    if (done !== 1'b1 || sum_out !== 8'h46 || cout_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: done=%b sum=%h cout=%b want 1 46 0",
               done, sum_out, cout_out);
    end
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf;
    issue(8'h7F, 8'h01, 1'b0);
    repeat (W + 1) @(negedge clk);
    checks++;
    if (done !== 1'b1 || sum_out !== 8'h80 || cout_out !== 1'b0
        || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf: done=%b sum=%h cout=%b ovf=%b want 1 80 0 1",
               done, sum_out, cout_out, ovf);
    end
  endtask
`endif

  task automatic test_ignored_start;
    int dones;
    int busy_late;
    issue(8'h3C, 8'h0F, 1'b1);
    dones = 0;
    busy_late = 0;
    for (int c = 1; c <= W + 1; c++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      start = (c == 3 || c == W + 1);
      a_in  = 8'hEE;
      b_in  = 8'hEE;
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) dones++;
      if (busy === 1'b1) busy_late++;
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL ign_dones: got=%0d want 1", dones);
    end
    checks++;
    if (busy_late != 0) begin
      errors++;
      $display("FAIL ign_busy: busy_cycles=%0d want 0", busy_late);
    end
    checks++;
    if (sum_out !== 8'h4C || cout_out !== 1'b0) begin
      errors++;
      $display("FAIL ign_sum: sum=%h cout=%b want 4C 0", sum_out, cout_out);
    end
  endtask

  task automatic test_rst_mid_add;
    int dones;
    issue(8'h11, 8'h22, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ctrl: busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (sum_out !== 8'h00 || cout_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_data: sum=%h cout=%b want 00 0",
               sum_out, cout_out);
    end
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL rst_mid_quiet: active_cycles=%0d want 0", dones);
    end
    issue(8'h30, 8'h0C, 1'b1);
    repeat (W + 1) @(negedge clk);
    checks++;
    if (done !== 1'b1 || sum_out !== 8'h3D || cout_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: done=%b sum=%h cout=%b want 1 3D 0",
               done, sum_out, cout_out);
    end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_wrap;
    test_back_to_back;
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf;
`endif
    test_ignored_start;
    test_rst_mid_add;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
